// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
// Read-side sequencer for the weight buffer. On a start command it walks an
// R x C weight matrix stored row-major at base_addr, issuing one single-word
// read per cycle into the buffer's 1-cycle-latency read port. Returned words
// are packed into a MAX_DIM-lane row word and handed to the matrix-multiply
// unit over a valid/ready handshake, one row per transfer.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          command pulse (sampled in IDLE), synchronous abort
//   base_addr             matrix base address
//   num_rows, num_cols    matrix dimensions, legal 1..MAX_DIM
//   busy, done, error     status: active, completion pulse, rejection pulse
//   buf_rd_en/addr        buffer read request
//   buf_rd_data/valid     buffer read response (one cycle after the request)
//   row_data/idx/last     presented row, its index, last-row flag
//   row_valid, row_ready  row handshake
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE    | waiting for start; range check on the command
// FETCH   | issuing the C reads of the current row
// WAIT    | reads issued, waiting for the remaining data to return
// PRESENT | row word valid, waiting for row_ready
module weight_fetch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_DIM    = 8,
    parameter int DIM_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [DIM_WIDTH-1:0]          num_rows,
    input  logic [DIM_WIDTH-1:0]          num_cols,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          buf_rd_en,
    output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]         buf_rd_data,
    input  logic                          buf_rd_valid,
    output logic [MAX_DIM*DATA_WIDTH-1:0] row_data,
    output logic [DIM_WIDTH-1:0]          row_idx,
    output logic                          row_last,
    output logic                          row_valid,
    input  logic                          row_ready
);

    localparam int EW = ADDR_WIDTH + 2;
    localparam int RW = MAX_DIM * DATA_WIDTH;
    localparam logic [DIM_WIDTH-1:0] ONE   = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] MAX_D = DIM_WIDTH'(MAX_DIM);
    localparam logic [EW-1:0]        DEPTH = EW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

    state_t                  state_q, state_d;
    logic [DIM_WIDTH-1:0]    rows_q, rows_d;
    logic [DIM_WIDTH-1:0]    cols_q, cols_d;
    logic [DIM_WIDTH-1:0]    col_q, col_d;
    logic [DIM_WIDTH-1:0]    cap_cnt_q, cap_cnt_d;
    logic [DIM_WIDTH-1:0]    out_cnt_q, out_cnt_d;
    logic [DIM_WIDTH-1:0]    row_idx_q, row_idx_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic [RW-1:0]           row_data_q, row_data_d;
    logic                    row_valid_q, row_valid_d;
    logic                    row_last_q, row_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    // End address of the command in a widened domain so it cannot wrap.
    logic [EW-1:0] end_addr;
    logic          reject;
    logic          cap;

    assign end_addr = EW'(base_addr) + EW'(num_rows) * EW'(num_cols);
    assign reject   = (num_rows == '0) || (num_cols == '0) ||
                      (num_rows > MAX_D) || (num_cols > MAX_D) ||
                      (end_addr > DEPTH);

    // Read data is only taken while this controller has a read in flight.
    assign cap = ((state_q == FETCH) || (state_q == WAIT)) &&
                 buf_rd_valid && (out_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        col_d       = col_q;
        cap_cnt_d   = cap_cnt_q;
        out_cnt_d   = out_cnt_q;
        row_idx_d   = row_idx_q;
        rd_addr_d   = rd_addr_q;
        rd_en_d     = rd_en_q;
        row_data_d  = row_data_q;
        row_valid_d = row_valid_q;
        row_last_d  = row_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case ({rd_en_q, cap})
            2'b10:   out_cnt_d = out_cnt_q + ONE;
            2'b01:   out_cnt_d = out_cnt_q - ONE;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (cap) begin
            for (int k = 0; k < MAX_DIM; k++) begin
                if (cap_cnt_q == DIM_WIDTH'(k)) begin
                    row_data_d[k*DATA_WIDTH +: DATA_WIDTH] = buf_rd_data;
                end
            end
            cap_cnt_d = cap_cnt_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d = num_rows;
                    cols_d = num_cols;
                    if (reject) begin
                        error_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        busy_d     = 1'b1;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = base_addr;
                        col_d      = '0;
                        cap_cnt_d  = '0;
                        out_cnt_d  = '0;
                        row_idx_d  = '0;
                        row_data_d = '0;
                    end
                end
            end
            FETCH: begin
                if (col_q == cols_q - ONE) begin
                    rd_en_d = 1'b0;
                    state_d = WAIT;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    col_d     = col_q + ONE;
                end
            end
            WAIT: begin
                if (cap && (cap_cnt_q == cols_q - ONE)) begin
                    state_d     = PRESENT;
                    row_valid_d = 1'b1;
                    row_last_d  = (row_idx_q == rows_q - ONE);
                end
            end
            PRESENT: begin
                if (row_ready) begin
                    row_valid_d = 1'b0;
                    row_last_d  = 1'b0;
                    if (row_last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Rows are contiguous, so the next row starts one past
                        // the last address read.
                        state_d    = FETCH;
                        row_idx_d  = row_idx_q + ONE;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = rd_addr_q + 1'b1;
                        col_d      = '0;
                        cap_cnt_d  = '0;
                        row_data_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            rd_en_d     = 1'b0;
            row_valid_d = 1'b0;
            row_last_d  = 1'b0;
            out_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            col_q       <= '0;
            cap_cnt_q   <= '0;
            out_cnt_q   <= '0;
            row_idx_q   <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            col_q       <= col_d;
            cap_cnt_q   <= cap_cnt_d;
            out_cnt_q   <= out_cnt_d;
            row_idx_q   <= row_idx_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign buf_rd_en   = rd_en_q;
    assign buf_rd_addr = rd_addr_q;
    assign row_data    = row_data_q;
    assign row_idx     = row_idx_q;
    assign row_last    = row_last_q;
    assign row_valid   = row_valid_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Testbench for weight_fetch_ctrl: directed commands against a 1-cycle
// latency buffer model (mem[a] = a). Expected reads and rows are queued when
// a command is issued; a monitor pops and compares as the DUT presents them.
module tb_weight_fetch_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int MD   = 8;
    localparam int DIMW = 4;
    localparam int RW   = MD * DW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [DIMW-1:0] num_rows = '0;
    logic [DIMW-1:0] num_cols = '0;
    logic            busy, done, error;
    logic            buf_rd_en;
    logic [AW-1:0]   buf_rd_addr;
    logic [DW-1:0]   buf_rd_data = '0;
    logic            buf_rd_valid = 1'b0;
    logic [RW-1:0]   row_data;
    logic [DIMW-1:0] row_idx;
    logic            row_last, row_valid;
    logic            row_ready = 1'b1;

    typedef struct packed {
        logic [RW-1:0]   data;
        logic [DIMW-1:0] idx;
        logic            last;
    } row_t;

    row_t          exp_rows[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] mem [1024];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    weight_fetch_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DIM(MD), .DIM_WIDTH(DIMW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .num_rows(num_rows), .num_cols(num_cols),
        .busy(busy), .done(done), .error(error),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data), .buf_rd_valid(buf_rd_valid),
        .row_data(row_data), .row_idx(row_idx), .row_last(row_last),
        .row_valid(row_valid), .row_ready(row_ready)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    end

    always @(posedge clk) begin
        buf_rd_valid <= buf_rd_en;
        buf_rd_data  <= mem[buf_rd_addr];
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (buf_rd_en) begin
                if (exp_addr.size() == 0) fail_now("unexpected_read");
                else check("rd_addr", RW'(buf_rd_addr), RW'(exp_addr.pop_front()));
            end
            if (row_valid && row_ready) begin
                if (exp_rows.size() == 0) begin
                    fail_now("unexpected_row");
                end else begin
                    row_t e;
                    e = exp_rows.pop_front();
                    check("row_data", row_data, e.data);
                    check("row_idx", RW'(row_idx), RW'(e.idx));
                    check("row_last", RW'(row_last), RW'(e.last));
                end
            end
            if (done)  done_cnt++;
            if (error) err_cnt++;
        end
    end

    function automatic logic [RW-1:0] model_row(input int base, input int r, input int c);
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < c; k++) v[k*DW +: DW] = DW'(base + r*c + k);
        return v;
    endfunction

    task automatic push_cmd(input int base, input int r, input int c);
        row_t e;
        for (int i = 0; i < r*c; i++) exp_addr.push_back(AW'(base + i));
        for (int rr = 0; rr < r; rr++) begin
            e.data = model_row(base, rr, c);
            e.idx  = DIMW'(rr);
            e.last = (rr == r - 1);
            exp_rows.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int base, input int r, input int c);
        base_addr = AW'(base);
        num_rows  = DIMW'(r);
        num_cols  = DIMW'(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", RW'(busy), RW'(0));
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!row_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_timeout", RW'(row_valid), RW'(1));
    endtask

    initial begin
        int n, d0, e0;
        logic [RW-1:0] held;

        // Reset state
        repeat (3) tick();
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_rd_en", RW'(buf_rd_en), RW'(0));
        check("rst_row_valid", RW'(row_valid), RW'(0));
        check("rst_row_data", row_data, RW'(0));
        rst_n = 1'b1;
        tick();

        // 3x4 at base 8
        d0 = done_cnt;
        push_cmd(8, 3, 4);
        issue(8, 3, 4);
        n = 1;
        while (!row_valid && n < 50) begin
            tick();
            n++;
        end
        check("first_valid_latency", RW'(n), RW'(6));
        wait_idle(200);
        check("t1_done_count", RW'(done_cnt - d0), RW'(1));

        // Full 8x8 at base 0
        d0 = done_cnt;
        push_cmd(0, 8, 8);
        issue(0, 8, 8);
        n = 0;
        while (!(row_valid && row_last) && n < 500) begin
            tick();
            n++;
        end
        check("t2_last_timeout", RW'(row_valid && row_last), RW'(1));
        tick();
        check("t2_done_after_last", RW'(done), RW'(1));
        check("t2_busy_after_last", RW'(busy), RW'(0));
        tick();
        check("t2_done_one_cycle", RW'(done), RW'(0));
        check("t2_done_count", RW'(done_cnt - d0), RW'(1));

        // Backpressure on row 1 of a 3x4 at base 100
        row_ready = 1'b0;
        push_cmd(100, 3, 4);
        issue(100, 3, 4);
        wait_valid(50);
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
        wait_valid(50);
        check("bp_row_idx", RW'(row_idx), RW'(1));
        held = row_data;
        for (int i = 0; i < 5; i++) begin
            check("bp_data_hold", row_data, held);
            check("bp_valid_hold", RW'(row_valid), RW'(1));
            check("bp_no_read", RW'(buf_rd_en), RW'(0));
            tick();
        end
        row_ready = 1'b1;
        tick();
        check("bp_next_read_en", RW'(buf_rd_en), RW'(1));
        check("bp_next_read_addr", RW'(buf_rd_addr), RW'(108));
        wait_idle(200);

        // Range checks
        e0 = err_cnt;
        issue(16, 2, 0);
        check("cols0_error", RW'(error), RW'(1));
        check("cols0_busy", RW'(busy), RW'(0));
        tick();
        check("cols0_error_pulse", RW'(error), RW'(0));
        check("cols0_busy_later", RW'(busy), RW'(0));
        tick();

        push_cmd(1020, 1, 4);
        issue(1020, 1, 4);
        check("base1020_no_error", RW'(error), RW'(0));
        check("base1020_busy", RW'(busy), RW'(1));
        wait_idle(100);

        issue(1021, 1, 4);
        check("base1021_error", RW'(error), RW'(1));
        check("base1021_busy", RW'(busy), RW'(0));
        tick();
        tick();
        check("error_count", RW'(err_cnt - e0), RW'(2));

        // Abort in second FETCH cycle of 2x8 at base 200
        d0 = done_cnt;
        exp_addr.push_back(AW'(200));
        exp_addr.push_back(AW'(201));
        issue(200, 2, 8);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", RW'(busy), RW'(0));
        check("abort_row_valid", RW'(row_valid), RW'(0));
        check("abort_rd_en", RW'(buf_rd_en), RW'(0));
        push_cmd(300, 1, 1);
        issue(300, 1, 1);
        wait_idle(50);
        check("abort_done_count", RW'(done_cnt - d0), RW'(1));

        // Reset during PRESENT
        row_ready = 1'b0;
        push_cmd(400, 2, 3);
        issue(400, 2, 3);
        wait_valid(50);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", RW'(busy), RW'(0));
        check("arst_row_valid", RW'(row_valid), RW'(0));
        check("arst_row_data", row_data, RW'(0));
        check("arst_row_idx", RW'(row_idx), RW'(0));
        check("arst_rd_addr", RW'(buf_rd_addr), RW'(0));
        exp_rows.delete();
        exp_addr.delete();
        tick();
        tick();
        rst_n = 1'b1;
        row_ready = 1'b1;
        tick();
        d0 = done_cnt;
        push_cmd(500, 1, 2);
        issue(500, 1, 2);
        wait_idle(50);
        check("post_rst_done_count", RW'(done_cnt - d0), RW'(1));

        repeat (3) tick();
        check("rows_left", RW'(exp_rows.size()), RW'(0));
        check("addrs_left", RW'(exp_addr.size()), RW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Read-side sequencer for the weight buffer. On a start command it walks an R×C weight matrix stored row-major at a base address and issues single-word reads into the buffer's 1-cycle-latency read port. It packs each returned row into one wide lane word and presents it to the matrix-multiply unit over a valid/ready handshake, one row per transfer.

## Interface
- DATA_WIDTH, 16: width of one weight (Q8.8).
- ADDR_WIDTH, 10: buffer address width; buffer depth is 2^ADDR_WIDTH.
- MAX_DIM, 8: maximum rows and columns, and the number of output lanes.
- DIM_WIDTH, 4: width of dimension and index fields; must hold MAX_DIM.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command pulse; sampled only in IDLE.
- abort  in  1  synchronous abort.
- base_addr  in  ADDR_WIDTH  matrix base address.
- num_rows  in  DIM_WIDTH  row count R; legal range 1..MAX_DIM.
- num_cols  in  DIM_WIDTH  column count C; legal range 1..MAX_DIM.
- busy  out  1  high while a command is active.
- done  out  1  one-cycle pulse after the last row is accepted.
- error  out  1  one-cycle pulse when start is rejected.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  ADDR_WIDTH  buffer read address.
- buf_rd_data  in  DATA_WIDTH  buffer read data; valid one cycle after buf_rd_en.
- buf_rd_valid  in  1  buffer read-data valid.
- row_data  out  MAX_DIM*DATA_WIDTH  packed row; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- row_idx  out  DIM_WIDTH  index of the presented row.
- row_last  out  1  presented row is row R-1.
- row_valid  out  1  row_data is valid.
- row_ready  in  1  downstream accepts the row.

## Operation
- States: IDLE, FETCH, WAIT, PRESENT.
- IDLE, start=1:
  - Latch base_addr, R and C.
  - Reject the command if R=0, C=0, R>MAX_DIM, C>MAX_DIM, or base_addr + R·C > 2^ADDR_WIDTH. The check uses ADDR_WIDTH+2-bit arithmetic and never wraps.
  - If rejected: error=1 for one cycle, stay in IDLE, issue no reads.
  - Otherwise go to FETCH with row r=0.
- FETCH:
  - Issue C reads on consecutive cycles at base + r·C + c, for c = 0..C-1.
  - After the c=C-1 read, go to WAIT.
- Capture:
  - Each buf_rd_valid while a read is outstanding writes buf_rd_data into lane cap_cnt, then cap_cnt increments.
  - cap_cnt is cleared at the start of each row.
  - Lanes ≥ C are forced to 0.
  - buf_rd_valid with no read outstanding is ignored.
- WAIT: when the C-th datum is captured, go to PRESENT.
- PRESENT:
  - row_valid=1; row_idx=r; row_last=(r==R-1).
  - Transfer occurs on row_valid & row_ready.
  - On transfer: if r<R-1, r increments and the state goes to FETCH; otherwise go to IDLE and pulse done.
  - row_data, row_idx and row_last are held stable while row_valid=1 and row_ready=0.
- busy=1 in every state except IDLE. A start input while busy is ignored.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, row_valid=0, busy=0, no done pulse.
  - Late buf_rd_valid is dropped.
  - abort has priority over row_ready and over start.
- Reset values: busy, done, error, buf_rd_en, row_valid and row_last are 0; buf_rd_addr, row_data and row_idx are 0; state is IDLE.

## Timing
- start accepted in cycle T → buf_rd_en=1 in cycles T+1..T+C, with addresses base..base+C-1.
- Data returns in cycles T+2..T+C+1; row_valid=1 from cycle T+C+2.
- Row transfer in cycle H (not the last row) → next row's first read in cycle H+1.
- Per-row cost is C+2 cycles plus any backpressure cycles.
- Last-row transfer in cycle H → in cycle H+1, done=1, busy=0 and state is IDLE. A new start is accepted in H+1.
- error pulses in cycle T+1 after a rejected start in cycle T.
- All outputs are registered; there is no combinational path from any input to any output.
- Asynchronous reset mid-command clears everything immediately. Buffer data returning after reset is ignored.

## Test plan
- 3×4 matrix at base=8, buffer preloaded with mem[a]=a:
  - Rows {8,9,10,11}, {12..15}, {16..19} presented, lanes 4–7 = 0.
  - row_idx 0,1,2; row_last only on row 2; exactly one done pulse.
  - First row_valid exactly 6 cycles after start.
- Full 8×8 at base=0:
  - Addresses 0..63 issued strictly sequentially.
  - Each row has lane k = mem[8r+k].
  - done pulses one cycle after the 8th transfer.
- Backpressure: row_ready held low for 5 cycles on row 1.
  - row_data stays stable and no buf_rd_en is issued during the hold.
  - Row 2 reads begin the cycle after the transfer.
- Range checks:
  - num_cols=0 → error pulse, busy stays 0, no reads.
  - base=1020, 1×4 → accepted, reads 1020..1023.
  - base=1021, 1×4 → error.
- abort in the 2nd FETCH cycle of a 2×8 command:
  - Next cycle IDLE, no row_valid, no done.
  - An immediately following 1×1 command completes correctly.
- rst_n asserted during PRESENT:
  - All outputs go to 0 asynchronously.
  - After release, a 1×2 command returns correct data.
